// File: rtl/ring_shift_left_rx_pkg.sv
// Shared defaults and FSM state encoding for the ring shift register / serial receiver.
package ring_shift_left_rx_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int CNTW_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dff_ar.sv
// Single register bit: D flip-flop with asynchronous active-low clear and synchronous enable.
module dff_ar (
  input  logic clk,
  input  logic clear_n,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)
      q <= 1'b0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/ring_shift_left_rx.sv
// Left-shifting register that either rotates in place or receives a serial word MSB-first,
// pulsing word_valid for one cycle when a full word has been collected.
module ring_shift_left_rx
  import ring_shift_left_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             rotate,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             word_valid,
  output logic [CNTW-1:0]  bit_count
);

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t          state, state_next;
  logic [CNTW-1:0] cnt_next;
  logic [WIDTH-1:0] q_d;
  logic            q_en;

  assign serial_out = q[WIDTH-1];
  assign q_en       = preset | load | shift_en;

  // Bit-select: what each register bit takes when enabled, in priority order.
  always_comb begin
    q_d = q;
    if (preset)
      q_d = '1;
    else if (load)
      q_d = load_data;
    else if (rotate)
      q_d = {q[WIDTH-2:0], q[WIDTH-1]};
    else
      q_d = {q[WIDTH-2:0], serial_in};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_ar u_bit (
      .clk     (clk),
      .clear_n (clear_n),
      .en      (q_en),
      .d       (q_d[i]),
      .q       (q[i])
    );
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      bit_count  <= '0;
      word_valid <= 1'b0;
    end else begin
      state      <= state_next;
      bit_count  <= cnt_next;
      word_valid <= (state_next == DONE);
    end
  end

  // DONE is a single-cycle state: anything other than another receive shift drops back to IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = bit_count;
    if (preset || load) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (shift_en && !rotate) begin
      cnt_next   = (bit_count == LAST) ? '0 : bit_count + CNTW'(1);
      state_next = (state == RECV && bit_count == LAST) ? DONE : RECV;
    end else if (state == DONE) begin
      state_next = IDLE;
    end
  end

endmodule

// File: tb/tb_ring_shift_left_rx.sv
// Directed self-checking bench for ring_shift_left_rx with hand-computed expectations.
module tb_ring_shift_left_rx;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       preset;
  logic       load;
  logic [5:0] load_data;
  logic       shift_en;
  logic       rotate;
  logic       serial_in;
  logic [5:0] q;
  logic       serial_out;
  logic       word_valid;
  logic [2:0] bit_count;

  int errors = 0;
  int checks = 0;

  ring_shift_left_rx dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .preset     (preset),
    .load       (load),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .rotate     (rotate),
    .serial_in  (serial_in),
    .q          (q),
    .serial_out (serial_out),
    .word_valid (word_valid),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] pat;
    pat = 6'b111000;
    clear_n = 1'b0; preset = 0; load = 0; load_data = '0;
    shift_en = 0; rotate = 0; serial_in = 0;
    #2;
    checks++; if (q !== 6'b000000) begin errors++; $display("[TB] FAIL reset_q: got %b expected %b", q, 6'b000000); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bit_count); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wv: got %b expected 0", word_valid); end
    checks++; if (serial_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_sout: got %b expected 0", serial_out); end
    #1 clear_n = 1'b1;
    tick();
    // three received bits, then reset between edges
    for (int i = 0; i < 3; i++) begin
      shift_en = 1; serial_in = pat[5-i];
      tick();
    end
    checks++; if (bit_count !== 3'd3) begin errors++; $display("[TB] FAIL midword_cnt: got %0d expected 3", bit_count); end
    checks++; if (q !== 6'b000111) begin errors++; $display("[TB] FAIL midword_q: got %b expected %b", q, 6'b000111); end
    #2 clear_n = 1'b0;
    #1;
    checks++; if (q !== 6'b000000) begin errors++; $display("[TB] FAIL async_q: got %b expected %b", q, 6'b000000); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL async_cnt: got %0d expected 0", bit_count); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_wv: got %b expected 0", word_valid); end
    #1 clear_n = 1'b1; shift_en = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_wv[%0d]: got %b expected 0", i, word_valid); end
    end
  endtask

  task automatic test_serial_word();
    logic [5:0] word;
    word = 6'b101100;
    for (int i = 0; i < 6; i++) begin
      shift_en = 1; rotate = 0; serial_in = word[5-i];
      tick();
      checks++; if (bit_count !== 3'((i + 1) % 6)) begin errors++; $display("[TB] FAIL word_cnt[%0d]: got %0d expected %0d", i, bit_count, (i + 1) % 6); end
      checks++; if (word_valid !== (i == 5)) begin errors++; $display("[TB] FAIL word_wv[%0d]: got %b expected %b", i, word_valid, (i == 5)); end
    end
    checks++; if (q !== 6'b101100) begin errors++; $display("[TB] FAIL word_q: got %b expected %b", q, 6'b101100); end
    checks++; if (serial_out !== 1'b1) begin errors++; $display("[TB] FAIL word_sout: got %b expected 1", serial_out); end
    shift_en = 0;
    tick();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL word_wv_after: got %b expected 0", word_valid); end
    checks++; if (q !== 6'b101100) begin errors++; $display("[TB] FAIL word_hold_q: got %b expected %b", q, 6'b101100); end
  endtask

  task automatic test_rotation();
    logic [5:0] exp_q [6];
    exp_q = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
    load = 1; load_data = 6'b100000;
    tick();
    load = 0;
    checks++; if (q !== 6'b100000) begin errors++; $display("[TB] FAIL rot_load: got %b expected %b", q, 6'b100000); end
    rotate = 1; shift_en = 1; serial_in = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("[TB] FAIL rot_q[%0d]: got %b expected %b", i, q, exp_q[i]); end
      checks++; if (word_valid !== 1'b0 || bit_count !== 3'd0) begin errors++; $display("[TB] FAIL rot_wv_cnt[%0d]: got wv=%b cnt=%0d expected wv=0 cnt=0", i, word_valid, bit_count); end
    end
    rotate = 0; shift_en = 0;
  endtask

  task automatic test_priority();
    shift_en = 1; serial_in = 1;
    tick();
    tick();
    shift_en = 0;
    checks++; if (bit_count !== 3'd2) begin errors++; $display("[TB] FAIL prio_precnt: got %0d expected 2", bit_count); end
    preset = 1; load = 1; load_data = 6'b000000;
    tick();
    preset = 0; load = 0;
    checks++; if (q !== 6'b111111) begin errors++; $display("[TB] FAIL prio_q: got %b expected %b", q, 6'b111111); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL prio_cnt: got %0d expected 0", bit_count); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] stream;
    stream = 12'b110011_001110;
    for (int i = 0; i < 12; i++) begin
      shift_en = 1; rotate = 0; serial_in = stream[11-i];
      tick();
      checks++; if (word_valid !== (i == 5 || i == 11)) begin errors++; $display("[TB] FAIL b2b_wv[%0d]: got %b expected %b", i, word_valid, (i == 5 || i == 11)); end
      if (i == 5) begin
        checks++; if (q !== 6'b110011) begin errors++; $display("[TB] FAIL b2b_word1: got %b expected %b", q, 6'b110011); end
      end
      if (i == 6) begin
        checks++; if (bit_count !== 3'd1) begin errors++; $display("[TB] FAIL b2b_restart_cnt: got %0d expected 1", bit_count); end
      end
      if (i == 11) begin
        checks++; if (q !== 6'b001110) begin errors++; $display("[TB] FAIL b2b_word2: got %b expected %b", q, 6'b001110); end
      end
    end
    shift_en = 0;
    tick();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wv_end: got %b expected 0", word_valid); end
  endtask

  task automatic test_stall();
    logic [5:0] word;
    word = 6'b101011;
    load = 1; load_data = 6'b000000;
    tick();
    load = 0;
    for (int i = 0; i < 3; i++) begin
      shift_en = 1; serial_in = word[5-i];
      tick();
    end
    shift_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== 6'b000101 || bit_count !== 3'd3 || word_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got q=%b cnt=%0d wv=%b expected q=000101 cnt=3 wv=0", i, q, bit_count, word_valid); end
    end
    for (int i = 3; i < 6; i++) begin
      shift_en = 1; serial_in = word[5-i];
      tick();
    end
    shift_en = 0;
    checks++; if (q !== 6'b101011) begin errors++; $display("[TB] FAIL stall_q: got %b expected %b", q, 6'b101011); end
    checks++; if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_wv: got %b expected 1", word_valid); end
    checks++; if (bit_count !== 3'd0) begin errors++; $display("[TB] FAIL stall_cnt: got %0d expected 0", bit_count); end
    tick();
  endtask

  task automatic test_done_override();
    logic [5:0] word;
    word = 6'b010110;
    for (int i = 0; i < 6; i++) begin
      shift_en = 1; rotate = 0; serial_in = word[5-i];
      tick();
    end
    shift_en = 0;
    checks++; if (word_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_wv_done: got %b expected 1", word_valid); end
    load = 1; load_data = 6'b110001; shift_en = 1; serial_in = 1;
    tick();
    load = 0; shift_en = 0;
    checks++; if (q !== 6'b110001) begin errors++; $display("[TB] FAIL ovr_q: got %b expected %b", q, 6'b110001); end
    checks++; if (word_valid !== 1'b0 || bit_count !== 3'd0) begin errors++; $display("[TB] FAIL ovr_state: got wv=%b cnt=%0d expected wv=0 cnt=0", word_valid, bit_count); end
    shift_en = 1; serial_in = 0;
    tick();
    shift_en = 0;
    checks++; if (bit_count !== 3'd1 || q !== 6'b100010) begin errors++; $display("[TB] FAIL ovr_resume: got q=%b cnt=%0d expected q=100010 cnt=1", q, bit_count); end
  endtask

  initial begin
    test_reset();
    test_serial_word();
    test_rotation();
    test_priority();
    test_back_to_back();
    test_stall();
    test_done_override();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_shift_left_rx.md
RING_SHIFT_LEFT_RX -- requirements
Module: ring_shift_left_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, setting the register length in bits.
REQ-002 The block SHALL have parameter CNTW, default 3, setting the bit-counter width, equal to ceil(log2(WIDTH)).
REQ-003 Port clk SHALL be: input, 1 bit, the single clock, with all state updating on its posedge.
REQ-004 Port clear_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 Port preset SHALL be: input, 1 bit, synchronous force of all register bits to 1.
REQ-006 Port load SHALL be: input, 1 bit, synchronous parallel load of load_data.
REQ-007 Port load_data SHALL be: input, WIDTH bits, the parallel preload value.
REQ-008 Port shift_en SHALL be: input, 1 bit, one left shift per asserted clock edge.
REQ-009 Port rotate SHALL be: input, 1 bit; 1 selects circular left rotation and 0 selects serial receive.
REQ-010 Port serial_in SHALL be: input, 1 bit, the serial data bit, received MSB-first.
REQ-011 Port q SHALL be: output, WIDTH bits, the register contents.
REQ-012 Port serial_out SHALL be: output, 1 bit, equal to q[WIDTH-1] combinationally.
REQ-013 Port word_valid SHALL be: output, 1 bit, a one-cycle registered pulse marking a completed received word.
REQ-014 Port bit_count SHALL be: output, CNTW bits, the number of bits received in the current word.

Function
REQ-015 Per-edge priority SHALL be: preset, then load, then shift_en, then hold.
REQ-016 Preset SHALL set q to all ones, set bit_count to 0 and set state to IDLE.
REQ-017 Load SHALL set q to load_data, set bit_count to 0 and set state to IDLE.
REQ-018 Serial receive (shift_en=1, rotate=0) SHALL set q to {q[WIDTH-2:0], serial_in}.
REQ-019 Rotation (shift_en=1, rotate=1) SHALL set q to {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-020 Rotation SHALL NOT change bit_count or state.
REQ-021 Each serial-receive shift SHALL increment bit_count.
REQ-022 On the WIDTH-th serial-receive shift, bit_count SHALL wrap to 0.
REQ-023 FSM states SHALL be IDLE, RECV and DONE.
REQ-024 IDLE SHALL go to RECV on a serial-receive shift.
REQ-025 RECV SHALL stay in RECV while bit_count is below WIDTH after the shift.
REQ-026 RECV SHALL go to DONE on the WIDTH-th serial-receive shift.
REQ-027 DONE SHALL last exactly one cycle, with word_valid=1 only in DONE.
REQ-028 DONE SHALL go to RECV with bit_count=1 on a serial-receive shift, giving back-to-back words with no gap.
REQ-029 DONE SHALL go to IDLE otherwise.
REQ-030 While word_valid=1, q SHALL hold the complete word, with the first-received bit at q[WIDTH-1].
REQ-031 With shift_en=0 and no preset or load, q, bit_count and state SHALL hold.
REQ-032 In DONE, preset or load SHALL still override the register and go to IDLE; word_valid SHALL remain 1 for that cycle.

Reset
REQ-033 clear_n=0 SHALL force, asynchronously and without a clock edge: q=0, bit_count=0, word_valid=0, state=IDLE, and therefore serial_out=0.
REQ-034 A reset asserted mid-word SHALL discard the partial word, so that no word_valid follows.
REQ-035 The first clock edge after clear_n rises SHALL be processed normally.

Structure
REQ-036 A shared package SHALL hold the WIDTH default, the CNTW default and the state typedef (IDLE, RECV, DONE).
REQ-037 Each register bit SHALL be an instance of sub-module dff_ar: a D flip-flop with asynchronous active-low reset and synchronous enable.
REQ-038 The next-state logic and the bit-select logic SHALL be in ring_shift_left_rx.

Verification
REQ-039 Reset scenario: clear_n=0 asserted between edges after 3 received bits -> q=000000, bit_count=0 and word_valid=0 immediately, with no later pulse.
REQ-040 Serial word scenario: serial_in 1,0,1,1,0,0 over 6 edges -> q=101100 and word_valid=1 in the following cycle only; bit_count=0.
REQ-041 Rotation scenario: load 100000, then rotate=1, shift_en=1 for 6 edges -> q goes 000001, 000010, 000100, 001000, 010000, 100000; word_valid never asserts.
REQ-042 Priority scenario: preset=1 and load=1 with load_data=000000 on the same edge -> q=111111 and bit_count=0.
REQ-043 Back-to-back scenario: 12 continuous bits 110011 then 001110 -> word_valid pulses exactly 6 cycles apart, showing 110011 then 001110.
REQ-044 Stall scenario: shift_en=0 for 4 cycles after bit 3 -> q and bit_count=3 are held; the word completes after 3 more shifts.
